// File: rtl/decode_stage_param_if.sv
// ID-stage bundle: IF/ID inputs, WB port, hazard sources, hazard/branch outputs and ID/EX fields.
// Optional perf counter signals exist only when DECODE_PERF_CNT_EN is defined.
interface decode_stage_param_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int PC_W  = 32
);
    localparam int RA_W = $clog2(NREGS);

    logic            instr_valid;
    logic [31:0]     instruction;
    logic [PC_W-1:0] pc;
    logic            wb_enable;
    logic [RA_W-1:0] wb_addr;
    logic [XLEN-1:0] wb_data;
    logic [RA_W-1:0] ex_rd;
    logic [RA_W-1:0] mem_rd;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic            mem_mem_read;

    logic            pc_enable;
    logic            if_id_enable;
    logic            if_flush;
    logic            mux_sel_IF;
    logic [PC_W-1:0] branch_target;
    logic            id_ex_valid;
    logic            mem_to_reg_out;
    logic            reg_write_out;
    logic            mem_read_out;
    logic            mem_write_out;
    logic            branch_out;
    logic            aluSrc_out;
    logic [1:0]      aluOp_out;
    logic [RA_W-1:0] rs1_out;
    logic [RA_W-1:0] rs2_out;
    logic [RA_W-1:0] rd_out;
    logic [XLEN-1:0] imediato_out;
    logic [XLEN-1:0] reg_a_out;
    logic [XLEN-1:0] reg_b_out;
    logic [6:0]      funct7_out;
    logic [2:0]      funct3_out;
    logic            stall_debug;
`ifdef DECODE_PERF_CNT_EN
    logic [31:0]     perf_stall_cnt;
    logic [31:0]     perf_flush_cnt;
`endif

    modport slave (
        input  instr_valid, instruction, pc, wb_enable, wb_addr, wb_data,
               ex_rd, mem_rd, ex_reg_write, ex_mem_read, mem_mem_read,
        output pc_enable, if_id_enable, if_flush, mux_sel_IF, branch_target,
               id_ex_valid, mem_to_reg_out, reg_write_out, mem_read_out, mem_write_out,
               branch_out, aluSrc_out, aluOp_out, rs1_out, rs2_out, rd_out,
               imediato_out, reg_a_out, reg_b_out, funct7_out, funct3_out, stall_debug
`ifdef DECODE_PERF_CNT_EN
        , output perf_stall_cnt, perf_flush_cnt
`endif
    );

    modport master (
        output instr_valid, instruction, pc, wb_enable, wb_addr, wb_data,
               ex_rd, mem_rd, ex_reg_write, ex_mem_read, mem_mem_read,
        input  pc_enable, if_id_enable, if_flush, mux_sel_IF, branch_target,
               id_ex_valid, mem_to_reg_out, reg_write_out, mem_read_out, mem_write_out,
               branch_out, aluSrc_out, aluOp_out, rs1_out, rs2_out, rd_out,
               imediato_out, reg_a_out, reg_b_out, funct7_out, funct3_out, stall_debug
`ifdef DECODE_PERF_CNT_EN
        , input perf_stall_cnt, perf_flush_cnt
`endif
    );
endinterface

// File: rtl/decode_stage_param.sv
// Parametrised RISC-V ID stage: register file, decode, hazards, BEQ/BNE resolution, ID/EX register.
// Define DECODE_PERF_CNT_EN to add saturating stall/flush performance counters.
module decode_stage_param #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int PC_W  = 32
) (
    input logic                  clock,
    input logic                  reset,
    decode_stage_param_if.slave  bus
);
    localparam int RA_W = $clog2(NREGS);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic            valid;
        logic            mem_to_reg;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            alu_src;
        logic [1:0]      alu_op;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] reg_a;
        logic [XLEN-1:0] reg_b;
        logic [6:0]      funct7;
        logic [2:0]      funct3;
    } id_ex_t;

    function automatic logic signed [11:0] imm_i(input logic [31:0] ins);
        return signed'(ins[31:20]);
    endfunction

    function automatic logic signed [11:0] imm_s(input logic [31:0] ins);
        return signed'({ins[31:25], ins[11:7]});
    endfunction

    function automatic logic signed [12:0] imm_b(input logic [31:0] ins);
        return signed'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
    endfunction

    logic [XLEN-1:0] regs [NREGS];

    logic [6:0]             opcode_p0;
    logic [2:0]             funct3_p0;
    logic [RA_W-1:0]        rs1_p0;
    logic [RA_W-1:0]        rs2_p0;
    logic                   is_r, is_i, is_load, is_store, is_branch;
    logic                   known_p0;
    logic                   use_rs2_p0;
    logic signed [XLEN-1:0] imm_p0;
    logic [XLEN-1:0]        reg_a_p0;
    logic [XLEN-1:0]        reg_b_p0;
    logic                   load_use, branch_alu, branch_load;
    logic                   stall_p0;
    logic                   taken_p0;
    id_ex_t                 id_ex_p0;
    id_ex_t                 id_ex_p1;

    // ---- ID: field extraction, class decode, operand read with WB bypass ----
    always_comb begin
        opcode_p0  = bus.instruction[6:0];
        funct3_p0  = bus.instruction[14:12];
        rs1_p0     = bus.instruction[15 +: RA_W];
        rs2_p0     = bus.instruction[20 +: RA_W];

        is_r       = bus.instr_valid && (opcode_p0 == OP_R);
        is_i       = bus.instr_valid && (opcode_p0 == OP_I);
        is_load    = bus.instr_valid && (opcode_p0 == OP_LOAD);
        is_store   = bus.instr_valid && (opcode_p0 == OP_STORE);
        is_branch  = bus.instr_valid && (opcode_p0 == OP_BRANCH);
        known_p0   = is_r || is_i || is_load || is_store || is_branch;
        use_rs2_p0 = is_r || is_store || is_branch;

        imm_p0 = '0;
        if (is_i || is_load) imm_p0 = XLEN'(imm_i(bus.instruction));
        if (is_store)        imm_p0 = XLEN'(imm_s(bus.instruction));
        if (is_branch)       imm_p0 = XLEN'(imm_b(bus.instruction));

        // A WB write in this same cycle must be visible to the instruction in ID.
        reg_a_p0 = '0;
        if (rs1_p0 != '0)
            reg_a_p0 = (bus.wb_enable && bus.wb_addr == rs1_p0) ? bus.wb_data : regs[rs1_p0];
        reg_b_p0 = '0;
        if (rs2_p0 != '0)
            reg_b_p0 = (bus.wb_enable && bus.wb_addr == rs2_p0) ? bus.wb_data : regs[rs2_p0];
    end

    // ---- ID: hazard detection and early branch resolution ----
    always_comb begin
        load_use = bus.ex_mem_read && (bus.ex_rd != '0) &&
                   ((known_p0 && bus.ex_rd == rs1_p0) || (use_rs2_p0 && bus.ex_rd == rs2_p0));
        // Branches compare in ID, so any pending producer in EX, or a load still in MEM, blocks them.
        branch_alu  = is_branch && bus.ex_reg_write && (bus.ex_rd != '0) &&
                      (bus.ex_rd == rs1_p0 || bus.ex_rd == rs2_p0);
        branch_load = is_branch && bus.mem_mem_read && (bus.mem_rd != '0) &&
                      (bus.mem_rd == rs1_p0 || bus.mem_rd == rs2_p0);
        stall_p0    = load_use || branch_alu || branch_load;

        taken_p0 = !stall_p0 && is_branch &&
                   ((funct3_p0 == 3'b000 && reg_a_p0 == reg_b_p0) ||
                    (funct3_p0 == 3'b001 && reg_a_p0 != reg_b_p0));
    end

    assign bus.pc_enable     = !stall_p0;
    assign bus.if_id_enable  = !stall_p0;
    assign bus.stall_debug   = stall_p0;
    assign bus.if_flush      = taken_p0;
    assign bus.mux_sel_IF    = taken_p0;
    assign bus.branch_target = bus.pc + PC_W'(imm_b(bus.instruction));

    always_comb begin
        id_ex_p0            = '0;
        id_ex_p0.valid      = 1'b1;
        id_ex_p0.mem_to_reg = is_load;
        id_ex_p0.reg_write  = is_r || is_i || is_load;
        id_ex_p0.mem_read   = is_load;
        id_ex_p0.mem_write  = is_store;
        id_ex_p0.branch     = is_branch;
        id_ex_p0.alu_src    = is_i || is_load || is_store;
        id_ex_p0.alu_op     = (is_r || is_i) ? 2'b10 : (is_branch ? 2'b01 : 2'b00);
        id_ex_p0.rs1        = rs1_p0;
        id_ex_p0.rs2        = rs2_p0;
        id_ex_p0.rd         = bus.instruction[7 +: RA_W];
        id_ex_p0.imm        = imm_p0;
        id_ex_p0.reg_a      = reg_a_p0;
        id_ex_p0.reg_b      = reg_b_p0;
        id_ex_p0.funct7     = bus.instruction[31:25];
        id_ex_p0.funct3     = funct3_p0;
    end

    // ---- Register file write (WB) ----
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (bus.wb_enable && bus.wb_addr != '0) begin
            regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    // ---- ID/EX boundary: stalls and unknown opcodes become an all-zero bubble ----
    always_ff @(posedge clock) begin
        if (reset || stall_p0 || !known_p0) id_ex_p1 <= '0;
        else                                 id_ex_p1 <= id_ex_p0;
    end

    assign bus.id_ex_valid    = id_ex_p1.valid;
    assign bus.mem_to_reg_out = id_ex_p1.mem_to_reg;
    assign bus.reg_write_out  = id_ex_p1.reg_write;
    assign bus.mem_read_out   = id_ex_p1.mem_read;
    assign bus.mem_write_out  = id_ex_p1.mem_write;
    assign bus.branch_out     = id_ex_p1.branch;
    assign bus.aluSrc_out     = id_ex_p1.alu_src;
    assign bus.aluOp_out      = id_ex_p1.alu_op;
    assign bus.rs1_out        = id_ex_p1.rs1;
    assign bus.rs2_out        = id_ex_p1.rs2;
    assign bus.rd_out         = id_ex_p1.rd;
    assign bus.imediato_out   = id_ex_p1.imm;
    assign bus.reg_a_out      = id_ex_p1.reg_a;
    assign bus.reg_b_out      = id_ex_p1.reg_b;
    assign bus.funct7_out     = id_ex_p1.funct7;
    assign bus.funct3_out     = id_ex_p1.funct3;

`ifdef DECODE_PERF_CNT_EN
    logic [31:0] stall_cnt_p1;
    logic [31:0] flush_cnt_p1;

    // ---- Performance counters (saturating) ----
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_p1 <= '0;
            flush_cnt_p1 <= '0;
        end else begin
            if (stall_p0 && stall_cnt_p1 != 32'hFFFF_FFFF) stall_cnt_p1 <= stall_cnt_p1 + 32'd1;
            if (taken_p0 && flush_cnt_p1 != 32'hFFFF_FFFF) flush_cnt_p1 <= flush_cnt_p1 + 32'd1;
        end
    end

    assign bus.perf_stall_cnt = stall_cnt_p1;
    assign bus.perf_flush_cnt = flush_cnt_p1;
`endif
endmodule

// File: tb/tb_decode_stage_param.sv
// Self-checking bench for decode_stage_param: directed scenarios then randomized cycles vs a reference model.
module tb_decode_stage_param;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int PC_W  = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    decode_stage_param_if #(.XLEN(XLEN), .NREGS(NREGS), .PC_W(PC_W)) bus();
    decode_stage_param #(.XLEN(XLEN), .NREGS(NREGS), .PC_W(PC_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] mreg [NREGS];
`ifdef DECODE_PERF_CNT_EN
    logic [31:0] snap_stall;
    logic [31:0] snap_flush;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                          input int f3, input int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], OP_R};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], OP_BRANCH};
    endfunction

    function automatic logic [31:0] model_read(input int r);
        if (r == 0) return 32'd0;
        if (bus.wb_enable && bus.wb_addr == r) return bus.wb_data;
        return mreg[r];
    endfunction

    task automatic idle();
        bus.instr_valid  = 1'b0;
        bus.instruction  = 32'd0;
        bus.pc           = '0;
        bus.wb_enable    = 1'b0;
        bus.wb_addr      = '0;
        bus.wb_data      = '0;
        bus.ex_rd        = '0;
        bus.mem_rd       = '0;
        bus.ex_reg_write = 1'b0;
        bus.ex_mem_read  = 1'b0;
        bus.mem_mem_read = 1'b0;
    endtask

    // Predicts this cycle's combinational outputs and the ID/EX contents after the next edge.
    task automatic run_cycle(input string tag);
        logic [31:0] ins, a, b, imm, bimm, target;
        logic [6:0]  op;
        logic [7:0]  ctrl, obs_ctrl;
        logic        known, is_br, uses2, stall, taken, issue;
        int          rs1, rs2, rd, f3, f7;
        int          used[$];
        ins = bus.instruction;
        op  = ins[6:0];
        rs1 = int'((ins >> 15) & 32'd31);
        rs2 = int'((ins >> 20) & 32'd31);
        rd  = int'((ins >> 7) & 32'd31);
        f3  = int'((ins >> 12) & 32'd7);
        f7  = int'(ins >> 25);
        known = bus.instr_valid && (op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH});
        is_br = known && (op == OP_BRANCH);
        uses2 = known && (op inside {OP_R, OP_STORE, OP_BRANCH});
        a = model_read(rs1);
        b = model_read(rs2);
        if (known) used.push_back(rs1);
        if (uses2) used.push_back(rs2);
        stall = 1'b0;
        foreach (used[i]) begin
            if (used[i] != 0) begin
                if (bus.ex_mem_read && used[i] == bus.ex_rd) stall = 1'b1;
                if (is_br && bus.ex_reg_write && used[i] == bus.ex_rd) stall = 1'b1;
                if (is_br && bus.mem_mem_read && used[i] == bus.mem_rd) stall = 1'b1;
            end
        end
        taken = !stall && is_br && ((f3 == 0 && a == b) || (f3 == 1 && a != b));
        bimm = 32'(((int'(ins) >>> 31) * 4096) + int'((ins >> 7) & 1) * 2048 +
                   int'((ins >> 25) & 63) * 32 + int'((ins >> 8) & 15) * 2);
        target = bus.pc + bimm;
        imm  = 32'd0;
        ctrl = 8'd0;
        case (op)
            OP_R:      ctrl = 8'b01000010;
            OP_I:      begin ctrl = 8'b01000110; imm = 32'(int'(ins) >>> 20); end
            OP_LOAD:   begin ctrl = 8'b11100100; imm = 32'(int'(ins) >>> 20); end
            OP_STORE:  begin ctrl = 8'b00010100;
                             imm = 32'((int'(ins) >>> 25) * 32 + int'((ins >> 7) & 31)); end
            OP_BRANCH: begin ctrl = 8'b00001001; imm = bimm; end
            default:   ctrl = 8'd0;
        endcase
        #1;
        check({tag, " stall_debug"}, bus.stall_debug, stall);
        check({tag, " pc_enable"}, bus.pc_enable, !stall);
        check({tag, " if_id_enable"}, bus.if_id_enable, !stall);
        check({tag, " if_flush"}, bus.if_flush, taken);
        check({tag, " mux_sel_IF"}, bus.mux_sel_IF, taken);
        check({tag, " branch_target"}, bus.branch_target, target);
        @(posedge clock);
        issue = !reset && known && !stall;
        if (reset) begin
            foreach (mreg[i]) mreg[i] = 32'd0;
        end else if (bus.wb_enable && bus.wb_addr != 0) begin
            mreg[bus.wb_addr] = bus.wb_data;
        end
        #1;
        obs_ctrl = {bus.mem_to_reg_out, bus.reg_write_out, bus.mem_read_out, bus.mem_write_out,
                    bus.branch_out, bus.aluSrc_out, bus.aluOp_out};
        check({tag, " id_ex_valid"}, bus.id_ex_valid, issue);
        check({tag, " controls"}, obs_ctrl, issue ? ctrl : 8'd0);
        check({tag, " rs1_out"}, bus.rs1_out, issue ? rs1 : 0);
        check({tag, " rs2_out"}, bus.rs2_out, issue ? rs2 : 0);
        check({tag, " rd_out"}, bus.rd_out, issue ? rd : 0);
        check({tag, " imediato_out"}, bus.imediato_out, issue ? imm : 32'd0);
        check({tag, " reg_a_out"}, bus.reg_a_out, issue ? a : 32'd0);
        check({tag, " reg_b_out"}, bus.reg_b_out, issue ? b : 32'd0);
        check({tag, " funct7_out"}, bus.funct7_out, issue ? f7 : 0);
        check({tag, " funct3_out"}, bus.funct3_out, issue ? f3 : 0);
    endtask

    initial begin
        logic [31:0] w;
        logic [6:0]  op;
        int          sel;
        foreach (mreg[i]) mreg[i] = 32'd0;
        idle();
        reset = 1'b1;
        run_cycle("reset");
        check("reset id_ex_valid", bus.id_ex_valid, 1'b0);
        check("reset pc_enable", bus.pc_enable, 1'b1);
        check("reset if_id_enable", bus.if_id_enable, 1'b1);
        reset = 1'b0;

        // Write x5 = 7 while decoding add x6,x5,x5 in the same cycle.
        bus.wb_enable = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'd7;
        bus.instr_valid = 1'b1; bus.instruction = enc_r(0, 5, 5, 0, 6);
        run_cycle("add_bypass");
        check("add_bypass reg_a_out", bus.reg_a_out, 32'd7);
        check("add_bypass reg_b_out", bus.reg_b_out, 32'd7);
        check("add_bypass id_ex_valid", bus.id_ex_valid, 1'b1);

        // Load-use: lw x5 in EX, add x7,x5,x1 in ID.
        idle();
        bus.instr_valid = 1'b1; bus.instruction = enc_r(0, 1, 5, 0, 7);
        bus.ex_mem_read = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_rd = 5'd5;
        run_cycle("lu_stall");
        check("lu_stall stall_debug", bus.stall_debug, 1'b1);
        check("lu_stall bubble", bus.id_ex_valid, 1'b0);
        bus.ex_mem_read = 1'b0; bus.ex_reg_write = 1'b0; bus.ex_rd = '0;
        bus.mem_mem_read = 1'b1; bus.mem_rd = 5'd5;
        run_cycle("lu_issue");
        check("lu_issue id_ex_valid", bus.id_ex_valid, 1'b1);
        check("lu_issue rd_out", bus.rd_out, 5'd7);

        // x1 = x2 = 3, then beq/bne x1,x2,+16 at pc 0x40.
        idle();
        bus.wb_enable = 1'b1; bus.wb_addr = 5'd1; bus.wb_data = 32'd3;
        run_cycle("wb_x1");
        bus.wb_addr = 5'd2;
        run_cycle("wb_x2");
        idle();
        bus.instr_valid = 1'b1; bus.pc = 32'h40; bus.instruction = enc_b(16, 2, 1, 0);
`ifdef DECODE_PERF_CNT_EN
        snap_flush = bus.perf_flush_cnt;
`endif
        run_cycle("beq_taken");
        check("beq_taken mux_sel_IF", bus.mux_sel_IF, 1'b1);
        check("beq_taken if_flush", bus.if_flush, 1'b1);
        check("beq_taken branch_target", bus.branch_target, 32'h50);
        check("beq_taken id_ex_valid", bus.id_ex_valid, 1'b1);
`ifdef DECODE_PERF_CNT_EN
        check("beq_taken perf_flush delta", bus.perf_flush_cnt - snap_flush, 32'd1);
`endif
        bus.instruction = enc_b(16, 2, 1, 1);
        run_cycle("bne_not_taken");
        check("bne_not_taken mux_sel_IF", bus.mux_sel_IF, 1'b0);

        // lw x1 in EX feeding beq x1,x2: stall in EX, stall in MEM, resolve on the third cycle.
        bus.instruction = enc_b(16, 2, 1, 0);
        bus.ex_mem_read = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_rd = 5'd1;
`ifdef DECODE_PERF_CNT_EN
        snap_stall = bus.perf_stall_cnt;
`endif
        run_cycle("bl_ex");
        check("bl_ex stall_debug", bus.stall_debug, 1'b1);
        check("bl_ex mux_sel_IF", bus.mux_sel_IF, 1'b0);
        bus.ex_mem_read = 1'b0; bus.ex_reg_write = 1'b0; bus.ex_rd = '0;
        bus.mem_mem_read = 1'b1; bus.mem_rd = 5'd1;
        run_cycle("bl_mem");
        check("bl_mem stall_debug", bus.stall_debug, 1'b1);
        bus.mem_mem_read = 1'b0; bus.mem_rd = '0;
        run_cycle("bl_resolve");
        check("bl_resolve mux_sel_IF", bus.mux_sel_IF, 1'b1);
        check("bl_resolve id_ex_valid", bus.id_ex_valid, 1'b1);
`ifdef DECODE_PERF_CNT_EN
        check("bl perf_stall delta", bus.perf_stall_cnt - snap_stall, 32'd2);
`endif

        // Unknown opcode, invalid slot, and x0 write suppression.
        idle();
        bus.instr_valid = 1'b1; bus.instruction = 32'h0000_007F;
        run_cycle("bad_opcode");
        check("bad_opcode id_ex_valid", bus.id_ex_valid, 1'b0);
        check("bad_opcode reg_write_out", bus.reg_write_out, 1'b0);
        bus.instr_valid = 1'b0; bus.instruction = enc_r(0, 2, 1, 0, 3);
        run_cycle("invalid_slot");
        check("invalid_slot id_ex_valid", bus.id_ex_valid, 1'b0);
        bus.wb_enable = 1'b1; bus.wb_addr = '0; bus.wb_data = 32'd9;
        run_cycle("wb_x0");
        idle();
        bus.instr_valid = 1'b1; bus.instruction = enc_r(0, 0, 0, 0, 3);
        run_cycle("read_x0");
        check("read_x0 reg_a_out", bus.reg_a_out, 32'd0);

        // Reset arriving during a stall.
        bus.instruction = enc_r(0, 0, 1, 0, 3);
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd1;
        reset = 1'b1;
        run_cycle("reset_mid_stall");
        check("reset_mid_stall stall_debug", bus.stall_debug, 1'b1);
        reset = 1'b0;

        for (int n = 0; n < 250; n++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0:       op = OP_R;
                1:       op = OP_I;
                2:       op = OP_LOAD;
                3:       op = OP_STORE;
                4:       op = OP_BRANCH;
                default: op = 7'($urandom);
            endcase
            w = $urandom;
            w[6:0]   = op;
            w[11:7]  = 5'($urandom_range(0, 7));
            w[19:15] = 5'($urandom_range(0, 7));
            w[24:20] = 5'($urandom_range(0, 7));
            if (op == OP_BRANCH) w[14:12] = 3'($urandom_range(0, 2));
            bus.instruction  = w;
            bus.instr_valid  = ($urandom_range(0, 9) != 0);
            bus.pc           = $urandom;
            bus.wb_enable    = 1'($urandom_range(0, 1));
            bus.wb_addr      = 5'($urandom_range(0, 7));
            bus.wb_data      = $urandom_range(0, 3);
            bus.ex_rd        = 5'($urandom_range(0, 7));
            bus.mem_rd       = 5'($urandom_range(0, 7));
            bus.ex_reg_write = ($urandom_range(0, 2) == 0);
            bus.ex_mem_read  = ($urandom_range(0, 3) == 0);
            bus.mem_mem_read = ($urandom_range(0, 3) == 0);
            reset            = ($urandom_range(0, 49) == 0);
            run_cycle($sformatf("rnd%0d", n));
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
